// File: rtl/quadrilatero_skew_aligner_pkg.sv
// Shared types and helpers for the quadrilatero skew/deskew stage.
// Tap selection maps a lane index to its delay in advances for the active mode.
package quadrilatero_pkg;

    typedef enum logic {
        SKEW_MODE_SKEW,
        SKEW_MODE_DESKEW
    } skew_mode_e;

    typedef enum logic [1:0] {
        SA_IDLE,
        SA_STREAM,
        SA_DRAIN
    } skew_state_e;

    function automatic int unsigned skew_tap(input skew_mode_e mode,
                                             input int unsigned lane,
                                             input int unsigned width);
        return (mode == SKEW_MODE_SKEW) ? lane : width - 1 - lane;
    endfunction

endpackage

// File: rtl/quadrilatero_skew_lane.sv
// One lane of the skew stage: a data+tag delay line that shifts only on advance,
// with a runtime tap select; tap 0 is a zero-latency pass-through of the input.
module quadrilatero_skew_lane #(
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAP_W      = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  adv_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  tag_i,
    input  logic [TAP_W-1:0]      tap_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  tag_o
);

    if (DEPTH == 0) begin : g_wire
        assign data_o = data_i;
        assign tag_o  = tag_i;
    end else begin : g_line
        logic [DATA_WIDTH-1:0] dly_q [DEPTH];
        logic [DEPTH-1:0]      tag_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    dly_q[k] <= '0;
                end
                tag_q <= '0;
            end else if (adv_i) begin
                dly_q[0] <= data_i;
                tag_q[0] <= tag_i;
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    dly_q[k] <= dly_q[k-1];
                    tag_q[k] <= tag_q[k-1];
                end
            end
        end

        always_comb begin
            data_o = data_i;
            tag_o  = tag_i;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                if (tap_i == TAP_W'(k)) begin
                    data_o = dly_q[k-1];
                    tag_o  = tag_q[k-1];
                end
            end
        end
    end

endmodule

// File: rtl/quadrilatero_skew_aligner.sv
// Flow-controlled skew/deskew stage between row buffers and the systolic mesh.
// Lane i is delayed by i (SKEW) or MESH_WIDTH-1-i (DESKEW) advances; the tail drains itself.
module quadrilatero_skew_aligner
    import quadrilatero_pkg::*;
#(
    parameter int unsigned MESH_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             mode_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic                             last_i,
    input  logic [MESH_WIDTH*DATA_WIDTH-1:0] data_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [MESH_WIDTH*DATA_WIDTH-1:0] data_o,
    output logic [MESH_WIDTH-1:0]            lane_valid_o,
    output logic                             last_o,
    output logic                             busy_o
);

    localparam int unsigned DEPTH    = MESH_WIDTH - 1;
    localparam int unsigned TAP_W    = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1;
    localparam int unsigned CNT_W    = $clog2(MESH_WIDTH) + 1;
    localparam int unsigned LAST_CNT = (MESH_WIDTH > 1) ? MESH_WIDTH - 2 : 0;

    skew_state_e      state_q, state_d;
    skew_mode_e       mode_q, mode_d, mode_eff;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             adv;
    logic             draining;

    assign draining = (state_q == SA_DRAIN);
    assign adv      = valid_o && ready_i;
    assign busy_o   = (state_q != SA_IDLE);
    // The first beat is emitted while still IDLE, so it must see mode_i directly.
    assign mode_eff = (state_q == SA_IDLE) ? skew_mode_e'(mode_i) : mode_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SA_IDLE;
            mode_q  <= SKEW_MODE_SKEW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        ready_o = ready_i && !draining;
        valid_o = draining ? 1'b1 : valid_i;
        last_o  = 1'b0;
        case (state_q)
            SA_IDLE, SA_STREAM: begin
                last_o = (MESH_WIDTH == 1) && valid_i && last_i;
                if (valid_i && ready_i) begin
                    if (state_q == SA_IDLE) begin
                        mode_d = skew_mode_e'(mode_i);
                    end
                    if (last_i) begin
                        state_d = (MESH_WIDTH == 1) ? SA_IDLE : SA_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        state_d = SA_STREAM;
                    end
                end
            end
            SA_DRAIN: begin
                last_o = (cnt_q == CNT_W'(LAST_CNT));
                if (adv) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(LAST_CNT)) begin
                        state_d = SA_IDLE;
                    end
                end
            end
            default: state_d = SA_IDLE;
        endcase
    end

    for (genvar i = 0; i < MESH_WIDTH; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane_in;
        logic [DATA_WIDTH-1:0] lane_out;
        logic                  lane_tag;
        logic [TAP_W-1:0]      lane_tap;

        assign lane_in  = draining ? '0 : data_i[i*DATA_WIDTH +: DATA_WIDTH];
        assign lane_tap = TAP_W'(skew_tap(mode_eff, i, MESH_WIDTH));

        quadrilatero_skew_lane #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .TAP_W      (TAP_W)
        ) u_lane (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .adv_i  (adv),
            .data_i (lane_in),
            .tag_i  (valid_i && !draining),
            .tap_i  (lane_tap),
            .data_o (lane_out),
            .tag_o  (lane_tag)
        );

        assign lane_valid_o[i]                      = lane_tag;
        assign data_o[i*DATA_WIDTH +: DATA_WIDTH] = lane_tag ? lane_out : '0;
    end

endmodule

// File: tb/tb_quadrilatero_skew_aligner.sv
// Directed bench for the skew/deskew stage (4-lane and 1-lane instances, 8-bit lanes).
module tb_quadrilatero_skew_aligner;

    localparam int unsigned W  = 4;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          mode_i, valid_i, last_i, ready_i;
    logic [W*DW-1:0] data_i;
    logic          ready_o, valid_o, last_o, busy_o;
    logic [W*DW-1:0] data_o;
    logic [W-1:0]  lane_valid_o;

    logic          w1_mode_i, w1_valid_i, w1_last_i, w1_ready_i;
    logic [DW-1:0] w1_data_i, w1_data_o;
    logic          w1_ready_o, w1_valid_o, w1_last_o, w1_busy_o;
    logic [0:0]    w1_lane_valid_o;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    string         cur_test = "reset";

    logic [W*DW-1:0] in_rows  [8];
    logic [W*DW-1:0] exp_data [12];
    logic [W-1:0]    exp_lv   [12];
    int unsigned     n_in, n_exp;

    always #5 clk = ~clk;

    quadrilatero_skew_aligner #(.MESH_WIDTH(W), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .valid_i(valid_i), .ready_o(ready_o),
        .last_i(last_i), .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
        .data_o(data_o), .lane_valid_o(lane_valid_o), .last_o(last_o), .busy_o(busy_o)
    );

    quadrilatero_skew_aligner #(.MESH_WIDTH(1), .DATA_WIDTH(DW)) dut_w1 (
        .clk_i(clk), .rst_i(rst_i), .mode_i(w1_mode_i), .valid_i(w1_valid_i), .ready_o(w1_ready_o),
        .last_i(w1_last_i), .data_i(w1_data_i), .valid_o(w1_valid_o), .ready_i(w1_ready_i),
        .data_o(w1_data_o), .lane_valid_o(w1_lane_valid_o), .last_o(w1_last_o), .busy_o(w1_busy_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [%s] %s: got %0h expected %0h", cur_test, tag, act, exp);
        end
    endtask

    function automatic logic [W*DW-1:0] p4(input logic [7:0] l0, input logic [7:0] l1,
                                           input logic [7:0] l2, input logic [7:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic load_skew();
        n_in = 4;
        for (int r = 0; r < 4; r++) begin
            in_rows[r] = p4(8'(4*r+1), 8'(4*r+2), 8'(4*r+3), 8'(4*r+4));
        end
        n_exp = 7;
        exp_data[0] = p4(1, 0, 0, 0);     exp_lv[0] = 4'b0001;
        exp_data[1] = p4(5, 2, 0, 0);     exp_lv[1] = 4'b0011;
        exp_data[2] = p4(9, 6, 3, 0);     exp_lv[2] = 4'b0111;
        exp_data[3] = p4(13, 10, 7, 4);   exp_lv[3] = 4'b1111;
        exp_data[4] = p4(0, 14, 11, 8);   exp_lv[4] = 4'b1110;
        exp_data[5] = p4(0, 0, 15, 12);   exp_lv[5] = 4'b1100;
        exp_data[6] = p4(0, 0, 0, 16);    exp_lv[6] = 4'b1000;
    endtask

    task automatic load_deskew();
        n_in = 7;
        in_rows[0] = p4(1, 0, 0, 0);
        in_rows[1] = p4(5, 2, 0, 0);
        in_rows[2] = p4(9, 6, 3, 0);
        in_rows[3] = p4(13, 10, 7, 4);
        in_rows[4] = p4(0, 14, 11, 8);
        in_rows[5] = p4(0, 0, 15, 12);
        in_rows[6] = p4(0, 0, 0, 16);
        n_exp = 10;
        exp_data[0] = '0;                 exp_lv[0] = 4'b1000;
        exp_data[1] = '0;                 exp_lv[1] = 4'b1100;
        exp_data[2] = '0;                 exp_lv[2] = 4'b1110;
        exp_data[3] = p4(1, 2, 3, 4);     exp_lv[3] = 4'b1111;
        exp_data[4] = p4(5, 6, 7, 8);     exp_lv[4] = 4'b1111;
        exp_data[5] = p4(9, 10, 11, 12);  exp_lv[5] = 4'b1111;
        exp_data[6] = p4(13, 14, 15, 16); exp_lv[6] = 4'b1111;
        exp_data[7] = '0;                 exp_lv[7] = 4'b0111;
        exp_data[8] = '0;                 exp_lv[8] = 4'b0011;
        exp_data[9] = '0;                 exp_lv[9] = 4'b0001;
    endtask

    // Drives one burst and checks every cycle against the expected beat sequence;
    // a stalled beat must keep presenting the same expected values.
    task automatic run_burst(input logic mode, input bit rdy_toggle, input bit bubbles,
                             input bit mflip, input int unsigned abort_after);
        int unsigned row  = 0;
        int unsigned beat = 0;
        int unsigned cyc  = 0;
        int unsigned goal = (abort_after != 0) ? abort_after : n_exp;
        logic        exp_v;
        while (beat < goal && cyc < 200) begin
            @(negedge clk);
            ready_i = rdy_toggle ? (cyc % 2 == 0) : 1'b1;
            valid_i = (row < n_in) && (!bubbles || $urandom_range(0, 1) == 1);
            data_i  = valid_i ? in_rows[row] : '0;
            last_i  = valid_i && (row == n_in - 1);
            mode_i  = (mflip && row >= 1) ? !mode : mode;
            #1;
            exp_v = (row < n_in) ? valid_i : 1'b1;
            check_eq("valid_o", valid_o, exp_v);
            check_eq("ready_o", ready_o, ready_i && (row < n_in));
            check_eq("last_o", last_o, exp_v && (beat == n_exp - 1));
            check_eq("busy_o", busy_o, row > 0);
            if (exp_v) begin
                check_eq($sformatf("data_o beat%0d", beat + 1), data_o, exp_data[beat]);
                check_eq($sformatf("lane_valid_o beat%0d", beat + 1), lane_valid_o, exp_lv[beat]);
                if (ready_i) beat++;
            end
            if (valid_i && ready_i && row < n_in) row++;
            cyc++;
        end
        if (beat < goal) check_eq("timeout beats", beat, goal);
        @(negedge clk);
        valid_i = 1'b0;
        last_i  = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b1; mode_i = 1'b0; valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b1; data_i = '0;
        w1_mode_i = 1'b0; w1_valid_i = 1'b0; w1_last_i = 1'b0; w1_ready_i = 1'b1; w1_data_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check_eq("rst valid_o", valid_o, 0);
        check_eq("rst busy_o", busy_o, 0);
        check_eq("rst last_o", last_o, 0);
        check_eq("rst lane_valid_o", lane_valid_o, 0);
        check_eq("rst data_o", data_o, 0);
        check_eq("rst ready_o", ready_o, 1);

        cur_test = "skew";        load_skew();   run_burst(1'b0, 0, 0, 0, 0);
        cur_test = "deskew";      load_deskew(); run_burst(1'b1, 0, 0, 0, 0);
        cur_test = "backpressure"; load_skew();  run_burst(1'b0, 1, 0, 0, 0);
        cur_test = "bubbles";     load_skew();   run_burst(1'b0, 0, 1, 0, 0);
        cur_test = "mode_flip";   load_skew();   run_burst(1'b0, 0, 0, 1, 0);
        cur_test = "after_flip";  load_deskew(); run_burst(1'b1, 0, 0, 0, 0);

        cur_test = "mid_reset";   load_skew();   run_burst(1'b0, 0, 0, 0, 3);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check_eq("valid_o", valid_o, 0);
        check_eq("lane_valid_o", lane_valid_o, 0);
        check_eq("busy_o", busy_o, 0);
        check_eq("data_o", data_o, 0);
        cur_test = "post_reset";  load_skew();   run_burst(1'b0, 0, 0, 0, 0);

        cur_test = "width1";
        @(negedge clk);
        w1_valid_i = 1'b1; w1_data_i = 8'h5A; w1_last_i = 1'b0;
        #1;
        check_eq("data_o", w1_data_o, 8'h5A);
        check_eq("lane_valid_o", w1_lane_valid_o, 1);
        check_eq("valid_o", w1_valid_o, 1);
        check_eq("last_o", w1_last_o, 0);
        check_eq("ready_o", w1_ready_o, 1);
        @(negedge clk);
        w1_data_i = 8'hA5; w1_last_i = 1'b1;
        #1;
        check_eq("busy_o streaming", w1_busy_o, 1);
        check_eq("data_o last", w1_data_o, 8'hA5);
        check_eq("last_o last", w1_last_o, 1);
        @(negedge clk);
        w1_valid_i = 1'b0; w1_last_i = 1'b0; w1_data_i = '0;
        #1;
        check_eq("busy_o after last", w1_busy_o, 0);
        check_eq("lane_valid_o idle", w1_lane_valid_o, 0);
        check_eq("data_o idle", w1_data_o, 0);
        check_eq("last_o idle", w1_last_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
